// File: rtl/vec_mem_loader_pkg.sv
// Shared vector-unit types: host loader commands, loader FSM states and
// the data-memory write operation encoding.
package vec_mem_loader_pkg;

    localparam int unsigned WORD_BITS = 32;

    typedef enum logic [1:0] {
        CMD_LOAD_INST = 2'd0,
        CMD_LOAD_DATA = 2'd1,
        CMD_RUN       = 2'd2,
        CMD_DUMP      = 2'd3
    } VecLoaderCmd_t;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD_INST = 3'd1,
        ST_LOAD_DATA = 3'd2,
        ST_WRITE     = 3'd3,
        ST_RUN       = 3'd4,
        ST_DUMP_READ = 3'd5,
        ST_DUMP_SEND = 3'd6
    } VecLoaderState_t;

    // DMEM_WR_NONE is the idle (no-op) encoding.
    typedef enum logic [1:0] {
        DMEM_WR_NONE = 2'd0,
        DMEM_WR_ROW  = 2'd1
    } VecDataMemWriteOp_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [31:0] sat_inc32(input logic [31:0] value);
        return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/vec_row_packer.sv
// WIDTH x 32-bit row buffer. Shifting moves every lane down by one and
// inserts the new word at the top lane, so after WIDTH shifts the first
// word sits in lane 0 (serial-in pack); lane 0 is also the serial output.
// A parallel load captures a whole row at once for the dump path.
module vec_row_packer #(
    parameter int WIDTH = 16
) (
    input  logic                  clock,
    input  logic                  shift,
    input  logic                  load,
    input  logic [31:0]           in_word,
    input  logic [WIDTH*32-1:0]   load_row,
    output logic [WIDTH*32-1:0]   row
);

    // Parallel load wins over shift; otherwise shift one lane toward lane 0.
    // NOTE: pure datapath storage, every row is fully rewritten before it
    // is consumed, so it carries no reset.
    always_ff @(posedge clock) begin
        if (load) begin
            row <= load_row;
        end else if (shift) begin
            row <= {in_word, row[WIDTH*32-1:32]};
        end
    end

endmodule

// File: rtl/vec_mem_loader.sv
// Host-side loader for the vector unit: streams instructions and data rows
// into the memories, runs VecControl until it signals done, and dumps data
// rows back to the host one 32-bit lane at a time.
module vec_mem_loader
    import vec_mem_loader_pkg::*;
#(
    parameter int WIDTH                = 16,
    parameter int INST_MEM_ADDR_SIZE   = 32,
    parameter int DATA_MEM_ADDR_SIZE   = 32,
    parameter int INST_MEM_WIDTH_BYTES = 16
) (
    input  logic                            clock,
    input  logic                            reset,
    input  VecLoaderCmd_t                   host_cmd,
    input  logic [31:0]                     host_cmd_addr,
    input  logic [31:0]                     host_cmd_len,
    input  logic                            host_cmd_valid,
    output logic                            host_cmd_ready,
    input  logic [31:0]                     host_in_data,
    input  logic                            host_in_valid,
    output logic                            host_in_ready,
    output logic [31:0]                     host_out_data,
    output logic                            host_out_valid,
    input  logic                            host_out_ready,
    output logic                            inst_mem_write_en,
    output logic [INST_MEM_ADDR_SIZE-1:0]   inst_mem_write_addr,
    output logic [8*INST_MEM_WIDTH_BYTES-1:0] inst_mem_data_in,
    output VecDataMemWriteOp_t              data_mem_write_op,
    output logic [DATA_MEM_ADDR_SIZE-1:0]   data_mem_write_addr,
    output logic [WIDTH*32-1:0]             data_mem_data_in,
    output logic [DATA_MEM_ADDR_SIZE-1:0]   data_mem_read_addr,
    input  logic [WIDTH*32-1:0]             data_mem_data_out,
    output logic                            ctrl_reset,
    input  logic                            ctrl_done,
    output logic                            busy,
    output logic [31:0]                     run_cycles
);

    localparam int INST_BEATS = INST_MEM_WIDTH_BYTES / 4;
    localparam int CNT_W      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_INST_BEAT = CNT_W'(INST_BEATS - 1);
    localparam logic [CNT_W-1:0] LAST_LANE      = CNT_W'(WIDTH - 1);

    VecLoaderState_t      state, state_next;
    logic [31:0]          addr;
    logic [31:0]          remaining;
    logic [CNT_W-1:0]     cnt;
    logic                 load_inst;
    logic [WIDTH*32-1:0]  row_buf;

    logic cmd_fire, pk_shift, pk_load, beat_last, row_done;

    vec_row_packer #(.WIDTH(WIDTH)) u_packer (
        .clock    (clock),
        .shift    (pk_shift),
        .load     (pk_load),
        .in_word  (host_in_data),
        .load_row (data_mem_data_out),
        .row      (row_buf)
    );

    // State register; reset drops straight back to IDLE.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the values from before the edge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_next;
    end

    // Next-state and handshake/strobe decode.
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_next        = state;
        host_cmd_ready    = 1'b0;
        host_in_ready     = 1'b0;
        host_out_valid    = 1'b0;
        inst_mem_write_en = 1'b0;
        data_mem_write_op = DMEM_WR_NONE;
        cmd_fire          = 1'b0;
        pk_shift          = 1'b0;
        pk_load           = 1'b0;
        beat_last         = 1'b0;
        row_done          = 1'b0;
        case (state)
            ST_IDLE: begin
                host_cmd_ready = 1'b1;
                if (host_cmd_valid) begin
                    cmd_fire = 1'b1;
                    case (host_cmd)
                        CMD_LOAD_INST: state_next = ST_LOAD_INST;
                        CMD_LOAD_DATA: state_next = ST_LOAD_DATA;
                        CMD_RUN:       state_next = ST_RUN;
                        default:       state_next = ST_DUMP_READ;
                    endcase
                end
            end
            ST_LOAD_INST, ST_LOAD_DATA: begin
                beat_last = (state == ST_LOAD_INST) ? (cnt == LAST_INST_BEAT)
                                                    : (cnt == LAST_LANE);
                if (remaining == 32'd0) begin
                    state_next = ST_IDLE;
                end else begin
                    host_in_ready = 1'b1;
                    if (host_in_valid) begin
                        pk_shift = 1'b1;
                        if (beat_last) state_next = ST_WRITE;
                    end
                end
            end
            ST_WRITE: begin
                row_done = 1'b1;
                if (load_inst) inst_mem_write_en = 1'b1;
                else           data_mem_write_op = DMEM_WR_ROW;
                if (remaining == 32'd1) state_next = ST_IDLE;
                else if (load_inst)     state_next = ST_LOAD_INST;
                else                    state_next = ST_LOAD_DATA;
            end
            ST_RUN: begin
                if (ctrl_done) state_next = ST_IDLE;
            end
            ST_DUMP_READ: begin
                if (remaining == 32'd0) begin
                    state_next = ST_IDLE;
                end else begin
                    pk_load    = 1'b1;
                    state_next = ST_DUMP_SEND;
                end
            end
            ST_DUMP_SEND: begin
                host_out_valid = 1'b1;
                beat_last      = (cnt == LAST_LANE);
                if (host_out_ready) begin
                    pk_shift = 1'b1;
                    if (beat_last) begin
                        row_done   = 1'b1;
                        state_next = (remaining == 32'd1) ? ST_IDLE : ST_DUMP_READ;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Command latch, beat/lane counter, row address stepping and run timer.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            addr       <= 32'd0;
            remaining  <= 32'd0;
            cnt        <= '0;
            load_inst  <= 1'b0;
            run_cycles <= 32'd0;
        end else begin
            if (cmd_fire) begin
                addr      <= host_cmd_addr;
                remaining <= host_cmd_len;
                cnt       <= '0;
                load_inst <= (host_cmd == CMD_LOAD_INST);
                if (host_cmd == CMD_RUN) run_cycles <= 32'd0;
            end
            if (pk_shift) cnt <= beat_last ? '0 : cnt + CNT_W'(1);
            // Address wraps silently at the top of the address space.
            if (row_done) begin
                addr      <= addr + 32'd1;
                remaining <= remaining - 32'd1;
            end
            if (state == ST_RUN) run_cycles <= sat_inc32(run_cycles);
        end
    end

    // The instruction occupies the top INST_BEATS lanes after packing,
    // with its first beat in the lowest bits of that slice.
    assign inst_mem_data_in    = row_buf[WIDTH*32-1 -: 8*INST_MEM_WIDTH_BYTES];
    assign inst_mem_write_addr = addr[INST_MEM_ADDR_SIZE-1:0];
    assign data_mem_write_addr = addr[DATA_MEM_ADDR_SIZE-1:0];
    assign data_mem_read_addr  = addr[DATA_MEM_ADDR_SIZE-1:0];
    assign data_mem_data_in    = row_buf;
    assign host_out_data       = row_buf[31:0];
    assign ctrl_reset          = (state != ST_RUN);
    assign busy                = (state != ST_IDLE);

endmodule
